regfile_mp: RTL and testbench

Parameterised multi-port register file for the next-generation core datapath, replacing the fixed 32x32, two-read/one-write file. Provides NREAD combinational read ports and two clocked write ports, with register 0 hardwired to zero. After reset, a clear sequencer zeroes every entry, one per cycle, and then raises `init_done`. Optional write-to-read bypass supports the pipelined core.

---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parameterised register file with NREAD combinational read
// ports and two clocked write ports. Entry 0 reads as constant zero.
// After reset a clear sequencer zeroes entries 1..DEPTH-1, one per edge,
// then raises init_done.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding for the pipelined core).
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NREAD  = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NREAD*ADDR_W-1:0]  ra,
    output logic [NREAD*DATA_W-1:0]  rd,
    output logic                     init_done
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Depth widened by one bit so the range check also works when DEPTH
    // is an exact power of two.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    state_t              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   rf [DEPTH];
    logic [NREAD*DATA_W-1:0] rd_c;

    // Qualified write strobes: enabled, nonzero and inside the array.
    logic                wr0_ok;
    logic                wr1_ok;

    always_comb begin
        wr0_ok = we0 && (wa0 != '0) && ({1'b0, wa0} < DEPTH_X);
        wr1_ok = we1 && (wa1 != '0) && ({1'b0, wa1} < DEPTH_X);
    end

    // Sequencer, init flag and array storage; port 1 is assigned last so it
    // wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_idx   <= FIRST_IDX;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    rf[clr_idx] <= '0;
                    clr_idx     <= clr_idx + FIRST_IDX;
                    if (clr_idx == LAST_IDX) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr0_ok) begin
                        rf[wa0] <= wd0;
                    end
                    if (wr1_ok) begin
                        rf[wa1] <= wd1;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // Combinational read ports: zero for address 0, out-of-range addresses
    // and while clearing; optional forwarding of same-cycle write data.
    always_comb begin
        rd_c = '0;
        for (int unsigned i = 0; i < NREAD; i++) begin : g_read
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            a = ra[i*ADDR_W +: ADDR_W];
            d = '0;
            if ((state == RUN) && (a != '0) && ({1'b0, a} < DEPTH_X)) begin
                d = rf[a];
`ifdef REGFILE_BYPASS_EN
                if (wr0_ok && (wa0 == a)) begin
                    d = wd0;
                end
                if (wr1_ok && (wa1 == a)) begin
                    d = wd1;
                end
`endif
            end
            rd_c[i*DATA_W +: DATA_W] = d;
        end
    end

    assign rd = rd_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int NR = 2;
    localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic              init_done;

    int total;
    int bad;

    regfile_mp #(.DATA_W(DW), .DEPTH(DP), .NREAD(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we0       (we0),
        .wa0       (wa0),
        .wd0       (wd0),
        .we1       (we1),
        .wa1       (wa1),
        .wd1       (wd1),
        .ra        (ra),
        .rd        (rd),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        ra  = {5'd9, 5'd5};

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        chk("reset_init_done", 64'(init_done), 64'd0);
        chk("reset_rd", rd, 64'd0);

        // Release and count clear edges; a write to r3 is pulsed at edge 5
        @(negedge clk);
        rst_n = 1'b1;
        ra = {5'd3, 5'd5};
        for (int e = 1; e <= 31; e++) begin
            if (e == 5) begin
                we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0000AAAA;
            end
            @(posedge clk);
            #1;
            chk($sformatf("clear1_done_e%0d", e), 64'(init_done), 64'(e == 31));
            chk($sformatf("clear1_rd_e%0d", e), rd, 64'd0);
            @(negedge clk);
            we0 = 1'b0; wa0 = '0; wd0 = '0;
        end

        // Every address reads zero after clear (r3 write was ignored)
        for (int a = 0; a < DP; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            chk($sformatf("clear_read_r%0d", a), rd, 64'd0);
        end

        // Dual write to r5 and r9 on one edge
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        ra = {5'd9, 5'd5};
        #1;
        chk("dual_write_rd0", 64'(rd[31:0]), 64'h00000000DEADBEEF);
        chk("dual_write_rd1", 64'(rd[63:32]), 64'h0000000012345678);

        // Same-address conflict: port 1 wins
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2;
        @(posedge clk);
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;
        ra = {5'd5, 5'd7};
        #1;
        chk("conflict_r7", 64'(rd[31:0]), 64'h2);
        chk("conflict_r5_kept", 64'(rd[63:32]), 64'hDEADBEEF);

        // Write to r0 is discarded
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
        ra = {5'd0, 5'd0};
        @(posedge clk);
        @(negedge clk);
        we0 = 1'b0;
        #1;
        chk("r0_zero", rd, 64'd0);

        // Bypass: r4 preloaded with 0x1111, then written 0xCAFE while read
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h1111;
        @(posedge clk);
        @(negedge clk);
        we0 = 1'b0;
        ra = {5'd0, 5'd4};
        #1;
        chk("bypass_preload", 64'(rd[31:0]), 64'h1111);
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'hCAFE;
        #1;
        chk("bypass_same_cycle", 64'(rd[31:0]), BYP ? 64'hCAFE : 64'h1111);
        @(posedge clk);
        @(negedge clk);
        we1 = 1'b0;
        #1;
        chk("bypass_next_cycle", 64'(rd[31:0]), 64'hCAFE);

        // Reset in RUN drops init_done and forces zero reads
        @(negedge clk);
        rst_n = 1'b0;
        ra = {5'd9, 5'd4};
        @(posedge clk);
        #1;
        chk("run_reset_done", 64'(init_done), 64'd0);
        chk("run_reset_rd", rd, 64'd0);

        // Release, then reset again at clear edge 10
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midclear_reset_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("clear2_done_e%0d", e), 64'(init_done), 64'(e == 31));
            @(negedge clk);
        end

        // Previously written entries are cleared again
        ra = {5'd9, 5'd5};
        #1;
        chk("recleared_r5_r9", rd, 64'd0);
        ra = {5'd4, 5'd7};
        #1;
        chk("recleared_r7_r4", rd, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
